// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared types and constants for the MDU issue controller slice.
package mdu_issue_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 3;
   localparam int REG_W  = 5;

   // RV32M op codes as carried on req_op_i / mdu_op
   localparam logic [OP_W-1:0] OP_MUL    = 3'b000;
   localparam logic [OP_W-1:0] OP_MULH   = 3'b001;
   localparam logic [OP_W-1:0] OP_MULHSU = 3'b010;
   localparam logic [OP_W-1:0] OP_MULHU  = 3'b011;
   localparam logic [OP_W-1:0] OP_DIV    = 3'b100;
   localparam logic [OP_W-1:0] OP_DIVU   = 3'b101;
   localparam logic [OP_W-1:0] OP_REM    = 3'b110;
   localparam logic [OP_W-1:0] OP_REMU   = 3'b111;

   localparam logic [DATA_W-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [DATA_W-1:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DRAIN,
      RESP
   } mdu_ctrl_state_t;

   // Divide-family ops (DIV/DIVU/REM/REMU) all have op[2] set.
   function automatic logic is_divrem(input logic [OP_W-1:0] op);
      return op[2];
   endfunction

   // Remainder ops return the dividend / zero on corner cases instead of the quotient value.
   function automatic logic is_rem(input logic [OP_W-1:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Launch/response bus between the issue controller (master) and the iterative MDU (slave).
interface mdu_issue_ctrl_if;
   import mdu_issue_ctrl_pkg::*;

   logic              mdu_valid;
   logic [OP_W-1:0]   mdu_op;
   logic [DATA_W-1:0] mdu_rs1;
   logic [DATA_W-1:0] mdu_rs2;
   logic              mdu_ready;
   logic [DATA_W-1:0] mdu_rd;

   modport master (
      output mdu_valid,
      output mdu_op,
      output mdu_rs1,
      output mdu_rs2,
      input  mdu_ready,
      input  mdu_rd
   );

   modport slave (
      input  mdu_valid,
      input  mdu_op,
      input  mdu_rs1,
      input  mdu_rs2,
      output mdu_ready,
      output mdu_rd
   );

endinterface

// File: rtl/mdu_issue_ctrl_fastpath.sv
// Combinational resolver for RV32M division corner cases that need no iteration:
// divide by zero and the signed INT_MIN / -1 overflow.
module mdu_fastpath
   import mdu_issue_ctrl_pkg::*;
#(
   parameter bit ENABLE_FASTPATH = 1'b1
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] rs1,
   input  logic [DATA_W-1:0] rs2,
   output logic              hit,
   output logic [DATA_W-1:0] data
);

   logic div_zero;
   logic div_ovf;

   // Classify the operands and pick the architecturally defined result.
   always_comb begin
      div_zero = is_divrem(op) && (rs2 == '0);
      // Only the signed ops overflow; DIVU/REMU of the same bit patterns are ordinary.
      div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
      hit      = ENABLE_FASTPATH && (div_zero || div_ovf);
      data     = '0;
      if (div_zero) begin
         data = is_rem(op) ? rs1 : ALL_ONES;
      end else if (div_ovf) begin
         data = is_rem(op) ? '0 : INT_MIN;
      end
   end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Execute-stage front end for the iterative MDU: accepts one RV32M op, stalls the
// pipeline while the MDU works, and returns the result to writeback as a pulse.
module mdu_issue_ctrl
   import mdu_issue_ctrl_pkg::*;
#(
   parameter bit ENABLE_FASTPATH = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [OP_W-1:0]   req_op_i,
   input  logic [DATA_W-1:0] req_rs1_i,
   input  logic [DATA_W-1:0] req_rs2_i,
   input  logic [REG_W-1:0]  req_rd_i,
   input  logic              flush_i,
   output logic              stall_o,
   mdu_issue_ctrl_if.master  mdu_bus,
   output logic              wb_valid_o,
   output logic [REG_W-1:0]  wb_rd_o,
   output logic [DATA_W-1:0] wb_data_o
);

   mdu_ctrl_state_t   state_q;
   mdu_ctrl_state_t   state_d;

   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] rs1_q;
   logic [DATA_W-1:0] rs2_q;
   logic [REG_W-1:0]  rd_q;
   logic [REG_W-1:0]  wb_rd_q;
   logic [DATA_W-1:0] wb_data_q;

   logic              accept;
   logic              fp_hit;
   logic [DATA_W-1:0] fp_data;
   logic              req_ready;
   logic              stall;
   logic              mdu_valid;
   logic              wb_valid;

   // The corner-case check runs on the live request so the decision is made in the accept cycle.
   mdu_fastpath #(
      .ENABLE_FASTPATH (ENABLE_FASTPATH)
   ) u_fastpath (
      .op   (req_op_i),
      .rs1  (req_rs1_i),
      .rs2  (req_rs2_i),
      .hit  (fp_hit),
      .data (fp_data)
   );

   assign accept = (state_q == IDLE) && req_valid_i && !flush_i;

   // State register; a reset mid-operation needs no drain because the MDU shares rst_n.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      stall     = 1'b0;
      mdu_valid = 1'b0;
      wb_valid  = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            stall     = req_valid_i && !flush_i;
            if (accept) begin
               state_d = ((req_rd_i == '0) || fp_hit) ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            mdu_valid = 1'b1;
            stall     = req_valid_i;
            state_d   = flush_i ? DRAIN : WAIT;
         end
         WAIT: begin
            stall = req_valid_i;
            // A flush coinciding with the result consumes that result here; waiting in
            // DRAIN for another ready pulse would never end.
            if (mdu_bus.mdu_ready) begin
               state_d = flush_i ? IDLE : RESP;
            end else if (flush_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mdu_bus.mdu_ready) begin
               state_d = IDLE;
            end
         end
         RESP: begin
            wb_valid = (rd_q != '0) && !flush_i;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request capture and writeback registers; MDU operands stay put until the next accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         if (accept) begin
            op_q  <= req_op_i;
            rs1_q <= req_rs1_i;
            rs2_q <= req_rs2_i;
            rd_q  <= req_rd_i;
            if ((req_rd_i != '0) && fp_hit) begin
               wb_rd_q   <= req_rd_i;
               wb_data_q <= fp_data;
            end
         end
         if ((state_q == WAIT) && mdu_bus.mdu_ready && !flush_i) begin
            wb_rd_q   <= rd_q;
            wb_data_q <= mdu_bus.mdu_rd;
         end
      end
   end

   assign req_ready_o       = req_ready;
   assign stall_o           = stall;
   assign wb_valid_o        = wb_valid;
   assign wb_rd_o           = wb_rd_q;
   assign wb_data_o         = wb_data_q;
   assign mdu_bus.mdu_valid = mdu_valid;
   assign mdu_bus.mdu_op    = op_q;
   assign mdu_bus.mdu_rs1   = rs1_q;
   assign mdu_bus.mdu_rs2   = rs2_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural iterative MDU on the slave side.
module tb_mdu_issue_ctrl;
   import mdu_issue_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  req_op_i;
   logic [31:0] req_rs1_i;
   logic [31:0] req_rs2_i;
   logic [4:0]  req_rd_i;
   logic        flush_i;
   logic        stall_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;

   mdu_issue_ctrl_if mdu_bus ();

   mdu_issue_ctrl #(
      .ENABLE_FASTPATH (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_op_i    (req_op_i),
      .req_rs1_i   (req_rs1_i),
      .req_rs2_i   (req_rs2_i),
      .req_rd_i    (req_rd_i),
      .flush_i     (flush_i),
      .stall_o     (stall_o),
      .mdu_bus     (mdu_bus),
      .wb_valid_o  (wb_valid_o),
      .wb_rd_o     (wb_rd_o),
      .wb_data_o   (wb_data_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   launch_cnt = 0;
   int   wb_cnt = 0;
   int   mdu_lat = 3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference behaviour of the external MDU.
   function automatic logic [31:0] mdu_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [63:0] p;
      p = '0;
      case (op)
         OP_MUL:    p = {32'b0, a} * {32'b0, b};
         OP_MULH:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         OP_MULHSU: p = {{32{a[31]}}, a} * {32'b0, b};
         OP_MULHU:  p = {32'b0, a} * {32'b0, b};
         OP_DIV:    p[31:0] = (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
         OP_DIVU:   p[31:0] = (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    p[31:0] = (b == 0) ? a : 32'($signed(a) % $signed(b));
         default:   p[31:0] = (b == 0) ? a : a % b;
      endcase
      return (op == OP_MUL || op[2]) ? p[31:0] : p[63:32];
   endfunction

   // Behavioural MDU: takes a launch pulse, returns a one-cycle ready after mdu_lat cycles.
   initial begin : mdu_model
      logic        busy, prev_v, unstable;
      logic [2:0]  cap_op;
      logic [31:0] cap_a, cap_b;
      int          cnt;
      busy = 0; prev_v = 0; unstable = 0; cnt = 0;
      cap_op = '0; cap_a = '0; cap_b = '0;
      mdu_bus.mdu_ready = 1'b0;
      mdu_bus.mdu_rd    = '0;
      forever begin
         @(negedge clk);
         mdu_bus.mdu_ready = 1'b0;
         if (!rst_n) begin
            busy   = 0;
            prev_v = 0;
         end else begin
            if (busy) begin
               if (mdu_bus.mdu_op !== cap_op || mdu_bus.mdu_rs1 !== cap_a ||
                   mdu_bus.mdu_rs2 !== cap_b) unstable = 1;
               cnt--;
               if (cnt == 0) begin
                  busy = 0;
                  check("mdu_ops_stable", 32'(unstable), 32'd0);
                  mdu_bus.mdu_ready = 1'b1;
                  mdu_bus.mdu_rd    = mdu_calc(cap_op, cap_a, cap_b);
               end
            end
            if (mdu_bus.mdu_valid) begin
               launch_cnt++;
               check("mdu_valid_single_cycle", 32'(prev_v), 32'd0);
               cap_op   = mdu_bus.mdu_op;
               cap_a    = mdu_bus.mdu_rs1;
               cap_b    = mdu_bus.mdu_rs2;
               busy     = 1;
               unstable = 0;
               cnt      = mdu_lat;
            end
            prev_v = mdu_bus.mdu_valid;
         end
      end
   end

   // Writeback monitor: every pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (rst_n && wb_valid_o) begin
         wb_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_wb: got rd=%0d data=%h, expected no writeback", wb_rd_o, wb_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, "_wb_rd"}, 32'(wb_rd_o), 32'(mon_e.rd));
            check({mon_e.name, "_wb_data"}, wb_data_o, mon_e.data);
         end
      end
   end

   // Issue one request (caller sits just after a rising edge) and follow it to completion.
   task automatic do_req(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_data,
                         input int exp_launch, input int exp_lat);
      int n;
      bit done;
      launch_cnt = 0;
      if (rd != 0) exp_q.push_back('{rd, exp_data, name});
      req_valid_i = 1'b1;
      req_op_i    = op;
      req_rs1_i   = a;
      req_rs2_i   = b;
      req_rd_i    = rd;
      @(negedge clk);
      check({name, "_req_ready"}, 32'(req_ready_o), 32'd1);
      check({name, "_stall_accept"}, 32'(stall_o), 32'd1);
      n = 0;
      done = 0;
      while (!done && n < 200) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (!stall_o) done = 1;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got stall still high after %0d cycles, expected release", name, n);
      end else begin
         check({name, "_latency"}, 32'(n), 32'(exp_lat));
         check({name, "_wb_valid_at_release"}, 32'(wb_valid_o), 32'(rd != 0));
      end
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      check({name, "_launches"}, 32'(launch_cnt), 32'(exp_launch));
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
      check({tag, "_stall"}, 32'(stall_o), 32'd0);
      check({tag, "_mdu_valid"}, 32'(mdu_bus.mdu_valid), 32'd0);
      check({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
      check({tag, "_mdu_op"}, 32'(mdu_bus.mdu_op), 32'd0);
      check({tag, "_mdu_rs1"}, mdu_bus.mdu_rs1, 32'd0);
      check({tag, "_mdu_rs2"}, mdu_bus.mdu_rs2, 32'd0);
      check({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
      check({tag, "_wb_data"}, wb_data_o, 32'd0);
   endtask

   initial begin : stimulus
      int n;
      int wb_before;
      rst_n = 1'b0;
      req_valid_i = 1'b0;
      req_op_i = '0;
      req_rs1_i = '0;
      req_rs2_i = '0;
      req_rd_i = '0;
      flush_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Main function and fast-path corner cases
      mdu_lat = 3;
      do_req("mul_7x-3",      OP_MUL,  32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1, 5);
      do_req("divu_by0",      OP_DIVU, 32'd100,        32'd0,         5'd6,  32'hFFFF_FFFF, 0, 1);
      do_req("rem_ovf",       OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 0, 1);
      do_req("div_ovf",       OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, 1);
      do_req("remu_by0",      OP_REMU, 32'd55,         32'd0,         5'd12, 32'h0000_0037, 0, 1);
      do_req("div_by0",       OP_DIV,  32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 0, 1);
      do_req("divu_intmin",   OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1, 5);
      mdu_lat = 34;
      do_req("div_-20by3",    OP_DIV,  32'hFFFF_FFEC,  32'd3,         5'd8,  32'hFFFF_FFFA, 1, 36);
      do_req("remu_20by3",    OP_REMU, 32'd20,         32'd3,         5'd10, 32'h0000_0002, 1, 36);
      mdu_lat = 3;
      do_req("mulhu_rd0",     OP_MULHU, 32'hFFFF_FFFF, 32'd2,         5'd0,  32'h0,         0, 1);
      do_req("mulh_-2x3",     OP_MULH, 32'hFFFF_FFFE,  32'd3,         5'd14, 32'hFFFF_FFFF, 1, 5);

      // Flush while idle: nothing may be accepted
      launch_cnt = 0;
      wb_before = wb_cnt;
      req_valid_i = 1'b1; req_op_i = OP_MUL; req_rs1_i = 32'd1; req_rs2_i = 32'd1; req_rd_i = 5'd1;
      flush_i = 1'b1;
      @(negedge clk);
      check("flush_idle_stall", 32'(stall_o), 32'd0);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      req_valid_i = 1'b0;
      @(negedge clk);
      check("flush_idle_still_ready", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      #1;
      check("flush_idle_launches", 32'(launch_cnt), 32'd0);

      // Flush in the response cycle suppresses writeback
      req_valid_i = 1'b1; req_op_i = OP_DIVU; req_rs1_i = 32'd1; req_rs2_i = 32'd0; req_rd_i = 5'd15;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      flush_i = 1'b1;
      @(negedge clk);
      check("flush_resp_wb_valid", 32'(wb_valid_o), 32'd0);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      @(negedge clk);
      check("flush_resp_back_idle", 32'(req_ready_o), 32'd1);
      check("flush_resp_no_wb", 32'(wb_cnt - wb_before), 32'd0);
      @(posedge clk);
      #1;

      // Flush 5 cycles after issue: drain the in-flight divide and discard it
      mdu_lat = 34;
      launch_cnt = 0;
      wb_before = wb_cnt;
      req_valid_i = 1'b1; req_op_i = OP_DIV; req_rs1_i = 32'd1000; req_rs2_i = 32'd7; req_rd_i = 5'd9;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      req_valid_i = 1'b1; req_op_i = OP_MUL; req_rs1_i = 32'd2; req_rs2_i = 32'd3; req_rd_i = 5'd4;
      @(negedge clk);
      check("drain_stall", 32'(stall_o), 32'd0);
      check("drain_req_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      n = 0;
      @(negedge clk);
      while (!req_ready_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_o) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got req_ready_o=0 after %0d cycles, expected 1", n);
      end
      check("drain_no_wb", 32'(wb_cnt - wb_before), 32'd0);
      check("drain_launches", 32'(launch_cnt), 32'd1);
      @(posedge clk);
      #1;
      mdu_lat = 3;
      do_req("mul_after_drain", OP_MUL, 32'd2, 32'd3, 5'd4, 32'h0000_0006, 1, 5);

      // Reset while waiting on the MDU
      mdu_lat = 10;
      req_valid_i = 1'b1; req_op_i = OP_MUL; req_rs1_i = 32'd5; req_rs2_i = 32'd6; req_rd_i = 5'd3;
      repeat (3) begin
         @(posedge clk);
         #1;
         req_valid_i = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("wait_before_reset_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("midop_reset");
      @(posedge clk);
      #1;
      mdu_lat = 3;
      do_req("mul_after_reset", OP_MUL, 32'd5, 32'd6, 5'd3, 32'h0000_001E, 1, 5);

      repeat (20) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
